// File: rtl/line_data_memory_if.sv
// Request/response bundle between the data cache and the line backing store.
//   master : cache side  - drives request (is_input_valid, addr, mem_read,
//            mem_write, din), observes response (is_output_valid, dout, mem_ready)
//   slave  : memory side - the reverse
interface line_data_memory_if #(
  parameter int BLOCK_SIZE = 16
);
  logic                      is_input_valid;
  logic [31:0]               addr;
  logic                      mem_read;
  logic                      mem_write;
  logic [8*BLOCK_SIZE-1:0]   din;
  logic                      is_output_valid;
  logic [8*BLOCK_SIZE-1:0]   dout;
  logic                      mem_ready;

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din,
    input  is_output_valid, dout, mem_ready
  );

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din,
    output is_output_valid, dout, mem_ready
  );
endinterface

// File: rtl/line_data_memory.sv
// Whole-line backing store sitting below the set-associative data cache.
// Accepts one line read or write-back at a time, waits DELAY cycles, then
// commits the write or returns the line with a one-cycle is_output_valid pulse.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; drops any in-flight request and
//            makes every line read back as zero
//   bus    - slave side of line_data_memory_if (request, response, mem_ready)
// Parameters: MEM_DEPTH (lines, power of two), BLOCK_SIZE (bytes per line),
//   DELAY (1..255 cycles; the countdown register is 8 bits wide).
module line_data_memory #(
  parameter int MEM_DEPTH  = 16384,
  parameter int BLOCK_SIZE = 16,
  parameter int DELAY      = 50
) (
  input  logic              clk,
  input  logic              reset,
  line_data_memory_if.slave bus
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int LINE_W = 8 * BLOCK_SIZE;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                op_write_q, op_write_d;
  logic [LINE_W-1:0]   din_q, din_d;
  logic [LINE_W-1:0]   dout_q, dout_d;
  logic                commit_we;

  // Line storage: plain array with a registered read port so it maps to
  // block RAM. Block RAM cannot be cleared in one cycle, so a per-line
  // "written since reset" flag masks stale contents to zero instead.
  logic [LINE_W-1:0]   mem [MEM_DEPTH];
  logic [LINE_W-1:0]   ram_rd_q;
  logic [MEM_DEPTH-1:0] line_valid_q;

  // Only the low index bits select a line; the rest alias.
  logic addr_hi_unused;
  assign addr_hi_unused = ^bus.addr[31:IDX_W];

  logic req_ok;
  assign req_ok = bus.is_input_valid & (bus.mem_read ^ bus.mem_write);

  assign bus.mem_ready       = (state_q == IDLE);
  assign bus.is_output_valid = (state_q == RESP);
  assign bus.dout            = dout_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    op_write_d = op_write_q;
    din_d      = din_q;
    dout_d     = dout_q;
    commit_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d    = BUSY;
          cnt_d      = 8'(DELAY - 1);
          idx_d      = bus.addr[IDX_W-1:0];
          op_write_d = bus.mem_write;
          din_d      = bus.din;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          if (op_write_q) begin
            commit_we = 1'b1;
            state_d   = IDLE;
          end else begin
            dout_d  = line_valid_q[idx_q] ? ram_rd_q : '0;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      op_write_q <= 1'b0;
      din_q      <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_write_q <= op_write_d;
      din_q      <= din_d;
      dout_q     <= dout_d;
    end
  end

  // The read port follows idx_d, so it already points at the accepted line
  // from the acceptance edge onward; this keeps DELAY=1 correct. No write can
  // land on that line while a read is outstanding.
  always_ff @(posedge clk) begin
    if (commit_we && !reset) begin
      mem[idx_q] <= din_q;
    end
    ram_rd_q <= mem[idx_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid_q <= '0;
    end else if (commit_we) begin
      line_valid_q[idx_q] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_line_data_memory.sv
module tb_line_data_memory;
  localparam int MEM_DEPTH  = 16384;
  localparam int BLOCK_SIZE = 16;
  localparam int DELAY      = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_data_memory_if #(.BLOCK_SIZE(BLOCK_SIZE)) bus ();

  line_data_memory #(
    .MEM_DEPTH(MEM_DEPTH), .BLOCK_SIZE(BLOCK_SIZE), .DELAY(DELAY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Reference: sparse line store, absent entries read as zero.
  logic [127:0] model [int];
  logic [127:0] last_dout;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.addr           = $urandom;
    bus.din            = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge of cycle
  // DELAY+1 after acceptance, DUT idle again.
  task automatic txn(input bit is_wr, input logic [31:0] a, input logic [127:0] d, input bit junk);
    logic [15:0]  rdy_obs, ov_obs, rdy_exp, ov_exp;
    logic [127:0] pulse_dout, exp_d;
    int line;
    line       = int'(a & (MEM_DEPTH - 1));
    exp_d      = model.exists(line) ? model[line] : '0;
    rdy_obs    = '0;
    ov_obs     = '0;
    rdy_exp    = '0;
    ov_exp     = '0;
    pulse_dout = '0;
    check("ready_before_req", bus.mem_ready, 1);
    bus.is_input_valid = 1'b1;
    bus.addr           = a;
    bus.mem_read       = !is_wr;
    bus.mem_write      = is_wr;
    bus.din            = d;
    @(posedge clk);
    for (int c = 0; c <= DELAY + 1; c++) begin
      @(negedge clk);
      rdy_obs[c] = bus.mem_ready;
      ov_obs[c]  = bus.is_output_valid;
      if (bus.is_output_valid) pulse_dout = bus.dout;
      if (junk && c <= DELAY - 2) begin
        // Busy-period noise; must not be accepted nor disturb the request.
        bus.is_input_valid = 1'b1;
        bus.mem_read       = 1'($urandom_range(0, 1));
        bus.mem_write      = !bus.mem_read;
        bus.addr           = (c % 2 == 0) ? 32'h20 : $urandom;
        bus.din            = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        idle_inputs();
      end
    end
    for (int c = 0; c <= DELAY + 1; c++) begin
      rdy_exp[c] = is_wr ? (c >= DELAY) : (c >= DELAY + 1);
      ov_exp[c]  = !is_wr && (c == DELAY);
    end
    check("ready_timeline", rdy_obs, rdy_exp);
    check("valid_timeline", ov_obs, ov_exp);
    if (is_wr) begin
      model[line] = d;
    end else begin
      check("read_data", pulse_dout, exp_d);
      last_dout = exp_d;
    end
    check("dout_hold", bus.dout, last_dout);
    txn_no++;
    $display("txn %0d %s addr=%h line=%h data=%h junk=%0d", txn_no,
             is_wr ? "WR" : "RD", a, line[13:0], is_wr ? d : exp_d, junk);
  endtask

  // Requests with a bad op encoding must leave the block idle and silent.
  task automatic bad_op(input bit rd, input bit wr, input string tag);
    logic rdy_acc, ov_acc;
    rdy_acc = 1'b1;
    ov_acc  = 1'b0;
    bus.is_input_valid = 1'b1;
    bus.mem_read       = rd;
    bus.mem_write      = wr;
    bus.addr           = 32'h10;
    bus.din            = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < DELAY + 4; c++) begin
      @(negedge clk);
      rdy_acc &= bus.mem_ready;
      ov_acc  |= bus.is_output_valid;
    end
    idle_inputs();
    @(negedge clk);
    check({tag, "_ready"}, rdy_acc, 1);
    check({tag, "_no_resp"}, ov_acc, 0);
    $display("txn %0d BAD op rd=%0d wr=%0d ignored", ++txn_no, rd, wr);
  endtask

  localparam logic [127:0] DATA_A = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] DATA_B = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

  initial begin
    last_dout = '0;
    reset     = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_ready", bus.mem_ready, 1);
    check("reset_valid", bus.is_output_valid, 0);
    check("reset_dout", bus.dout, 0);

    txn(1'b0, 32'h10, '0, 1'b0);       // fresh line reads zero
    txn(1'b1, 32'h10, DATA_A, 1'b0);
    txn(1'b0, 32'h10, '0, 1'b0);       // read-after-write
    txn(1'b1, 32'h10, DATA_B, 1'b1);   // noise aimed at line 0x20 while busy
    txn(1'b0, 32'h20, '0, 1'b0);       // must still be zero
    txn(1'b0, 32'h10, '0, 1'b1);
    txn(1'b1, 32'h4010, DATA_A, 1'b0); // aliases line 0x10
    txn(1'b0, 32'h10, '0, 1'b0);

    bad_op(1'b1, 1'b1, "both_ops");
    bad_op(1'b0, 1'b0, "no_op");
    txn(1'b0, 32'h10, '0, 1'b0);

    // Random traffic over a small line pool with random upper address bits.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 7) * 16 + 8);
      txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
          1'($urandom_range(0, 1)));
    end

    // Reset two edges into a write: the write is dropped, all lines clear.
    bus.is_input_valid = 1'b1;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b1;
    bus.addr           = 32'h30;
    bus.din            = DATA_B;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model.delete();
    last_dout = '0;
    check("midreset_ready", bus.mem_ready, 1);
    check("midreset_valid", bus.is_output_valid, 0);
    check("midreset_dout", bus.dout, 0);
    $display("txn %0d RESET during write to 30", ++txn_no);
    repeat (DELAY + 2) @(negedge clk);
    check("midreset_no_resp", bus.is_output_valid, 0);
    txn(1'b0, 32'h30, '0, 1'b0);
    txn(1'b0, 32'h10, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
